dram_port_arbiter: RTL
======================

// Module: dram_port_arbiter
// PURPOSE
//  Shares the single DDR3 controller user port between two requesters: CPU (port 0) and DMA (port 1).
//  Sits between the CPU/DMA bus masters and the DRAM controller wrapper inside top; one transaction in flight at a time.
//  Round-robin on contention; the winner is held until its transaction completes.
// PARAMETERS
//  ADDR_WIDTH  24  word address width, shared by both requesters and the memory port
//  DATA_WIDTH  32  data word width; byte mask width is DATA_WIDTH/8
// PORTS
//  clk            in   1     system clock
//  rst_n          in   1     asynchronous active-low reset
//  pN_req         in   1     N=0,1: request; held high until pN_ack
//  pN_we          in   1     1=write, 0=read; stable while pN_req
//  pN_addr        in   AW    word address; stable while pN_req
//  pN_wdata       in   DW    write data; stable while pN_req
//  pN_wmask       in   DW/8  byte enables for writes
//  pN_rdata       out  DW    read data; valid in the pN_ack cycle
//  pN_ack         out  1     one-cycle completion pulse
//  mem_cmd_valid  out  1     command to controller
//  mem_cmd_ready  in   1     controller accepts the command when valid&&ready
//  mem_we, mem_addr, mem_wdata, mem_wmask   out   muxed copy of the granted requester
//  mem_rvalid     in   1     read data return strobe
//  mem_rdata      in   DW    read data
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (port 0 wins first tie), all outputs 0, pN_rdata=0.
//  FSM states: IDLE -> CMD -> (write: ACK | read: RWAIT -> ACK) -> IDLE.
//  IDLE: if any req, register grant. Exactly one req: grant that port. Both: grant !last_grant. Go to CMD.
//  CMD: mem_cmd_valid=1; mem_* driven from a registered copy of the granted port. Stay until
//   mem_cmd_ready. Then: write -> ACK; read -> RWAIT. last_grant updates on acceptance.
//  RWAIT: on mem_rvalid capture mem_rdata into pN_rdata of the grantee -> ACK.
//   A mem_rvalid arriving in the CMD acceptance cycle is impossible by controller contract; ignore it.
//  ACK: pN_ack=1 for the grantee for exactly one cycle -> IDLE. The non-grantee's ack stays 0.
//  Latency, uncontended write: req at cycle 0, cmd_valid at 1, ack at cmd-accept+1 (min 3 cycles).
//  Requesters must drop req in the cycle after ack. A req still high in IDLE is a new transaction.
//  No new grant until ACK completes; a requester arriving mid-transaction waits. Max wait = one transaction.
//  mem_cmd_valid never drops before ready (no retraction). Address, data and mask are stable while valid.
//  Reset mid-transaction: immediate return to IDLE with outputs 0; the controller side is reset by the same rst_n.
//  pN_rdata holds its last value until the next read completes for that port.
// CONFIGURATION
//  DRAM_ARB_STATS_EN defined: adds outputs stat_grants0/stat_grants1 (32b each, increment on command
//   acceptance) and stat_waits (32b, increments each cycle a non-granted req is high). All saturate at
//   all-ones and reset to 0.
//  Undefined: the ports and counters are absent; no other behaviour changes.
// STRUCTURE
//  Shared package/header (dram_arb_defs.vh): state encodings ARB_IDLE/ARB_CMD/ARB_RWAIT/ARB_ACK, and
//   the port index constants PORT_CPU=0 and PORT_DMA=1.
//  Single module; no sub-module. The stats counters sit inline under `ifdef DRAM_ARB_STATS_EN.
// TESTING
//  1. p0 write addr 0x000010 data 0xDEADBEEF, cmd_ready always 1 -> one mem cmd with we=1 and those
//     values; p0_ack pulses at cycle 3; p1_ack stays 0.
//  2. p1 read addr 0x0000A0, rvalid 5 cycles after acceptance with rdata 0x12345678 -> p1_rdata=0x12345678
//     in the p1_ack cycle.
//  3. p0 and p1 both req in the first cycle after reset -> order p0, p1, p0, p1 over 4 back-to-back
//     transactions per port.
//  4. cmd_ready held low for 10 cycles -> cmd_valid stays 1 and mem_addr is unchanged throughout;
//     ack follows acceptance.
//  5. rst_n low while in RWAIT -> all outputs 0 on the next edge; after release, a fresh p0 read completes.
//  6. With DRAM_ARB_STATS_EN: scenario 3 -> stat_grants0=4, stat_grants1=4, stat_waits>0.

Source files
------------

// File: rtl/dram_port_arbiter_pkg.sv
// Shared definitions for the two-port DRAM user-port arbiter.
// Holds the FSM state encoding, the requester index constants and small helpers.
// Nothing here carries state; it is imported by the arbiter.
package dram_port_arbiter_pkg;

    // Transaction sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CMD   = 2'd1,
        ARB_RWAIT = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_t;

    // Requester indices as they appear in grant/last-grant registers
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Pick the winner among the active requests; on a tie the port that did
    // not win last time gets the slot.
    function automatic logic pick_port(input logic req0, input logic req1,
                                       input logic last_grant);
        logic win;
        if (req0 && req1) begin
            win = ~last_grant;
        end else if (req1) begin
            win = PORT_DMA;
        end else begin
            win = PORT_CPU;
        end
        return win;
    endfunction

    // Saturating 32-bit increment for the statistics counters
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dram_port_arbiter.sv
// Purpose : shares one DRAM controller command port between CPU (port 0) and DMA (port 1), round-robin on ties.
// Latency : grant 1 cycle after req, command held until accepted, ack 1 cycle after accept (write) or rvalid (read).
// Backpressure: mem_cmd_valid and the muxed command stay stable until mem_cmd_ready; losers wait one transaction.
// Optional: define DRAM_ARB_STATS_EN to add saturating grant/wait statistics outputs.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef DRAM_ARB_STATS_EN
    output logic [31:0]             stat_grants0,
    output logic [31:0]             stat_grants1,
    output logic [31:0]             stat_waits,
`endif
    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [DATA_WIDTH-1:0]   p0_wdata,
    input  logic [DATA_WIDTH/8-1:0] p0_wmask,
    output logic [DATA_WIDTH-1:0]   p0_rdata,
    output logic                    p0_ack,
    input  logic                    p1_req,
    input  logic                    p1_we,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [DATA_WIDTH-1:0]   p1_wdata,
    input  logic [DATA_WIDTH/8-1:0] p1_wmask,
    output logic [DATA_WIDTH-1:0]   p1_rdata,
    output logic                    p1_ack,
    output logic                    mem_cmd_valid,
    input  logic                    mem_cmd_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    arb_state_t              state_q;
    logic                    grant_q;
    logic                    last_grant_q;
    logic                    cmd_valid_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [MASK_WIDTH-1:0]   wmask_q;
    logic                    ack0_q;
    logic                    ack1_q;
    logic [DATA_WIDTH-1:0]   rdata0_q;
    logic [DATA_WIDTH-1:0]   rdata1_q;

    logic                    grant_d;
    logic                    we_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [MASK_WIDTH-1:0]   wmask_d;

    // Candidate winner and its command fields, only consumed in IDLE
    always_comb begin
        grant_d = pick_port(p0_req, p1_req, last_grant_q);
        we_d    = (grant_d == PORT_DMA) ? p1_we    : p0_we;
        addr_d  = (grant_d == PORT_DMA) ? p1_addr  : p0_addr;
        wdata_d = (grant_d == PORT_DMA) ? p1_wdata : p0_wdata;
        wmask_d = (grant_d == PORT_DMA) ? p1_wmask : p0_wmask;
    end

    // Transaction FSM with registered command, ack and read-data outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= PORT_CPU;
            last_grant_q <= PORT_DMA;
            cmd_valid_q  <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (p0_req || p1_req) begin
                        grant_q     <= grant_d;
                        we_q        <= we_d;
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        wmask_q     <= wmask_d;
                        cmd_valid_q <= 1'b1;
                        state_q     <= ARB_CMD;
                    end
                end
                ARB_CMD: begin
                    if (mem_cmd_ready) begin
                        cmd_valid_q  <= 1'b0;
                        last_grant_q <= grant_q;
                        if (we_q) begin
                            ack0_q  <= (grant_q == PORT_CPU);
                            ack1_q  <= (grant_q == PORT_DMA);
                            state_q <= ARB_ACK;
                        end else begin
                            state_q <= ARB_RWAIT;
                        end
                    end
                end
                ARB_RWAIT: begin
                    if (mem_rvalid) begin
                        if (grant_q == PORT_DMA) begin
                            rdata1_q <= mem_rdata;
                            ack1_q   <= 1'b1;
                        end else begin
                            rdata0_q <= mem_rdata;
                            ack0_q   <= 1'b1;
                        end
                        state_q <= ARB_ACK;
                    end
                end
                ARB_ACK: begin
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_cmd_valid = cmd_valid_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign p0_ack        = ack0_q;
    assign p1_ack        = ack1_q;
    assign p0_rdata      = rdata0_q;
    assign p1_rdata      = rdata1_q;

`ifdef DRAM_ARB_STATS_EN
    logic [31:0] grants0_q;
    logic [31:0] grants1_q;
    logic [31:0] waits_q;
    logic        accept;
    logic        waiting;

    // A request is waiting whenever a transaction owned by the other port is in progress
    assign accept  = (state_q == ARB_CMD) && mem_cmd_ready;
    assign waiting = (state_q != ARB_IDLE) && ((grant_q == PORT_DMA) ? p0_req : p1_req);

    // Saturating grant and wait counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants0_q <= '0;
            grants1_q <= '0;
            waits_q   <= '0;
        end else begin
            if (accept && (grant_q == PORT_CPU)) begin
                grants0_q <= sat_inc(grants0_q);
            end
            if (accept && (grant_q == PORT_DMA)) begin
                grants1_q <= sat_inc(grants1_q);
            end
            if (waiting) begin
                waits_q <= sat_inc(waits_q);
            end
        end
    end

    assign stat_grants0 = grants0_q;
    assign stat_grants1 = grants1_q;
    assign stat_waits   = waits_q;
`endif

endmodule
